// File: rtl/filter_sequencer.sv
// filter_sequencer: debounces four active-low pushbuttons into a target filter
// selection, then applies that target to the pipeline only at a frame boundary.
// The pipeline is flushed and drained first, then reconfigured with a
// valid/ack handshake, so no frame is ever processed with two filters.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   key[3:0]      raw pushbuttons, active-low, asynchronous to clk
//   frame_start   one-cycle pulse at the first pixel of each frame
//   pipe_idle     pipeline holds no in-flight pixels
//   cfg_ack       pipeline has latched the new configuration
//   filter_type   active filter code
//   bypass        active bypass flag
//   flush         asks the pipeline to stop accepting pixels and drain
//   cfg_valid     new filter_type/bypass presented, held until cfg_ack
//   busy          reconfiguration in progress
//   timeout_err   sticky, a drain ran out of time and the switch was forced
module filter_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DRAIN_TIMEOUT   = 4096,
  parameter int unsigned NUM_FILTERS     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  input  logic       frame_start,
  input  logic       pipe_idle,
  input  logic       cfg_ack,
  output logic [1:0] filter_type,
  output logic       bypass,
  output logic       flush,
  output logic       cfg_valid,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned NUM_KEYS = 4;
  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DR_W     = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_FIRE = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_TIMEOUT - 1);
  localparam logic [1:0]      F_LAST  = 2'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_SWITCH,
    S_ACK
  } state_t;

  logic [NUM_KEYS-1:0] key_meta;
  logic [NUM_KEYS-1:0] key_sync;
  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] press_evt;
  logic [DB_W-1:0]     db_cnt [NUM_KEYS];

  logic [1:0] tgt_filter, tgt_filter_d;
  logic       tgt_bypass, tgt_bypass_d;
  logic [1:0] pend_filter, pend_filter_d;
  logic       pend_bypass, pend_bypass_d;

  state_t          state, state_d;
  logic [DR_W-1:0] drain_cnt, drain_cnt_d;
  logic [1:0]      filter_type_d;
  logic            bypass_d, flush_d, cfg_valid_d, busy_d, timeout_err_d;

  // Two-flop synchronizer; resets to the released level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= '1;
      key_sync <= '1;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
    end
  end

  assign pressed = ~key_sync;

  // Event fires on the edge where the counter steps onto DEBOUNCE_CYCLES;
  // saturation then blocks repeats until release clears the counter.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      press_evt[i] = pressed[i] && (db_cnt[i] == DB_FIRE);
    end
  end

  // Per-key debounce counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (!pressed[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] != DB_MAX) begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Target update; only the highest-priority event of a cycle is honoured
  always_comb begin
    tgt_filter_d = tgt_filter;
    tgt_bypass_d = tgt_bypass;
    if (press_evt[3]) begin
      tgt_filter_d = 2'd0;
      tgt_bypass_d = 1'b0;
    end else if (press_evt[2]) begin
      tgt_bypass_d = ~tgt_bypass;
    end else if (press_evt[0]) begin
      tgt_filter_d = (tgt_filter == F_LAST) ? 2'd0 : tgt_filter + 2'd1;
    end else if (press_evt[1]) begin
      tgt_filter_d = (tgt_filter == 2'd0) ? F_LAST : tgt_filter - 2'd1;
    end
  end

  // Sequencer next state and registered outputs. The target is captured at
  // frame_start so presses during a transaction wait for the next frame.
  always_comb begin
    state_d       = state;
    drain_cnt_d   = drain_cnt;
    pend_filter_d = pend_filter;
    pend_bypass_d = pend_bypass;
    filter_type_d = filter_type;
    bypass_d      = bypass;
    flush_d       = flush;
    cfg_valid_d   = cfg_valid;
    busy_d        = busy;
    timeout_err_d = timeout_err;

    unique case (state)
      S_IDLE: begin
        if (frame_start && ((tgt_filter != filter_type) || (tgt_bypass != bypass))) begin
          state_d       = S_DRAIN;
          drain_cnt_d   = '0;
          pend_filter_d = tgt_filter;
          pend_bypass_d = tgt_bypass;
          flush_d       = 1'b1;
          busy_d        = 1'b1;
        end
      end
      S_DRAIN: begin
        if (pipe_idle || (drain_cnt == DR_LAST)) begin
          state_d       = S_SWITCH;
          filter_type_d = pend_filter;
          bypass_d      = pend_bypass;
          cfg_valid_d   = 1'b1;
          if (!pipe_idle) begin
            timeout_err_d = 1'b1;
          end
        end else begin
          drain_cnt_d = drain_cnt + DR_W'(1);
        end
      end
      S_SWITCH: begin
        if (cfg_ack) begin
          state_d     = S_ACK;
          cfg_valid_d = 1'b0;
          flush_d     = 1'b0;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        flush_d     = 1'b0;
        cfg_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State, target and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      drain_cnt   <= '0;
      tgt_filter  <= 2'd0;
      tgt_bypass  <= 1'b0;
      pend_filter <= 2'd0;
      pend_bypass <= 1'b0;
      filter_type <= 2'd0;
      bypass      <= 1'b0;
      flush       <= 1'b0;
      cfg_valid   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      drain_cnt   <= drain_cnt_d;
      tgt_filter  <= tgt_filter_d;
      tgt_bypass  <= tgt_bypass_d;
      pend_filter <= pend_filter_d;
      pend_bypass <= pend_bypass_d;
      filter_type <= filter_type_d;
      bypass      <= bypass_d;
      flush       <= flush_d;
      cfg_valid   <= cfg_valid_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_filter_sequencer.sv
// Bench for filter_sequencer: directed scenarios plus randomized key/frame
// traffic, checked against a target/active selection model kept here.
module tb_filter_sequencer;

  localparam int D = 4;   // debounce cycles
  localparam int T = 16;  // drain timeout
  localparam int N = 4;   // number of filters

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic       frame_start;
  logic       pipe_idle;
  logic       cfg_ack;
  logic [1:0] filter_type;
  logic       bypass;
  logic       flush;
  logic       cfg_valid;
  logic       busy;
  logic       timeout_err;

  int vectors;
  int miscompares;

  // Reference model: requested and applied selection, sticky timeout
  int tgt_f, act_f;
  bit tgt_b, act_b;
  bit tmo;

  filter_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .DRAIN_TIMEOUT  (T),
    .NUM_FILTERS    (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .frame_start(frame_start),
    .pipe_idle  (pipe_idle),
    .cfg_ack    (cfg_ack),
    .filter_type(filter_type),
    .bypass     (bypass),
    .flush      (flush),
    .cfg_valid  (cfg_valid),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Highest-priority simultaneous press wins: 3 > 2 > 0 > 1
  task automatic apply_mask(input logic [3:0] m);
    if (m[3]) begin
      tgt_f = 0;
      tgt_b = 1'b0;
    end else if (m[2]) begin
      tgt_b = ~tgt_b;
    end else if (m[0]) begin
      tgt_f = (tgt_f + 1) % N;
    end else if (m[1]) begin
      tgt_f = (tgt_f + N - 1) % N;
    end
  endtask

  task automatic model_reset();
    tgt_f = 0; tgt_b = 1'b0;
    act_f = 0; act_b = 1'b0;
    tmo   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    key = 4'hF; frame_start = 1'b0; cfg_ack = 1'b0; pipe_idle = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Hold the keys in mask low for len cycles, then release and let it settle
  task automatic press_mask(input logic [3:0] mask, input int len);
    @(negedge clk);
    key = ~mask;
    repeat (len) @(negedge clk);
    key = 4'hF;
    repeat (4) @(negedge clk);
    if (len >= D) apply_mask(mask);
  endtask

  // One frame boundary; d = DRAIN cycles with pipe_idle low, sw_mask = keys
  // pressed while the new configuration waits for cfg_ack
  task automatic frame_txn(input int d, input int ack_dly, input logic [3:0] sw_mask);
    bit exp_txn;
    int k;
    int pf;
    bit pb;
    int exp_k;
    exp_txn = (tgt_f != act_f) || (tgt_b != act_b);
    pf = tgt_f;
    pb = tgt_b;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    vectors++;
    if (flush !== exp_txn || busy !== exp_txn) begin
      miscompares++;
      $display("FAIL frame_flush: flush=%0b busy=%0b expected %0b", flush, busy, exp_txn);
    end
    if (!exp_txn) begin
      cfg_ack = 1'b1;
      @(negedge clk);
      cfg_ack = 1'b0;
      vectors++;
      if (cfg_valid !== 1'b0 || busy !== 1'b0 || filter_type !== 2'(act_f) || bypass !== act_b) begin
        miscompares++;
        $display("FAIL idle_stable: cfg_valid=%0b busy=%0b filter=%0d bypass=%0b expected 0 0 %0d %0b",
                 cfg_valid, busy, filter_type, bypass, act_f, act_b);
      end
      return;
    end
    k = 0;
    while (cfg_valid !== 1'b1 && k < 64) begin
      pipe_idle = (k >= d);
      @(negedge clk);
      k++;
    end
    pipe_idle = 1'b1;
    exp_k = (d + 1 < T) ? d + 1 : T;
    if (d >= T) tmo = 1'b1;
    vectors++;
    if (k !== exp_k) begin
      miscompares++;
      $display("FAIL drain_len: got %0d cycles expected %0d", k, exp_k);
    end
    vectors++;
    if (filter_type !== 2'(pf) || bypass !== pb || flush !== 1'b1) begin
      miscompares++;
      $display("FAIL switch_cfg: filter=%0d bypass=%0b flush=%0b expected %0d %0b 1",
               filter_type, bypass, flush, pf, pb);
    end
    vectors++;
    if (timeout_err !== tmo) begin
      miscompares++;
      $display("FAIL timeout_err: got %0b expected %0b", timeout_err, tmo);
    end
    if (sw_mask != 4'h0 && ack_dly < 12) ack_dly = 12;
    for (int i = 0; i < ack_dly; i++) begin
      if (sw_mask != 4'h0) key = (i < 8) ? ~sw_mask : 4'hF;
      @(negedge clk);
      frame_start = (i == 2);
    end
    frame_start = 1'b0;
    if (sw_mask != 4'h0) apply_mask(sw_mask);
    vectors++;
    if (cfg_valid !== 1'b1 || filter_type !== 2'(pf) || bypass !== pb) begin
      miscompares++;
      $display("FAIL cfg_hold: cfg_valid=%0b filter=%0d bypass=%0b expected 1 %0d %0b",
               cfg_valid, filter_type, bypass, pf, pb);
    end
    cfg_ack = 1'b1;
    @(negedge clk);
    cfg_ack = 1'b0;
    vectors++;
    if (cfg_valid !== 1'b0 || flush !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_state: cfg_valid=%0b flush=%0b busy=%0b expected 0 0 1", cfg_valid, flush, busy);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || filter_type !== 2'(pf) || bypass !== pb) begin
      miscompares++;
      $display("FAIL back_idle: busy=%0b filter=%0d bypass=%0b expected 0 %0d %0b", busy, filter_type, bypass, pf, pb);
    end
    act_f = pf;
    act_b = pb;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key = 4'hF; frame_start = 1'b0; pipe_idle = 1'b1; cfg_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({filter_type, bypass, flush, cfg_valid, busy, timeout_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 0000000", {filter_type, bypass, flush, cfg_valid, busy, timeout_err});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    press_mask(4'b0001, 10);
    frame_txn(0, 1, 4'h0);
  endtask

  task automatic test_glitch();
    press_mask(4'b0001, 3);
    vectors++;
    if (flush !== 1'b0 || filter_type !== 2'(act_f)) begin
      miscompares++;
      $display("FAIL glitch: flush=%0b filter=%0d expected 0 %0d", flush, filter_type, act_f);
    end
    frame_txn(0, 0, 4'h0);
    press_mask(4'b0001, 100);
    frame_txn(2, 1, 4'h0);
  endtask

  task automatic test_wrap();
    do_reset();
    press_mask(4'b0010, 6);
    frame_txn(1, 0, 4'h0);
    press_mask(4'b0001, 6);
    press_mask(4'b0001, 6);
    frame_txn(0, 2, 4'h0);
  endtask

  task automatic test_frame_sync();
    press_mask(4'b0001, 6);
    for (int i = 0; i < 10; i++) begin
      repeat (100) @(negedge clk);
      vectors++;
      if (flush !== 1'b0 || busy !== 1'b0 || filter_type !== 2'(act_f)) begin
        miscompares++;
        $display("FAIL no_frame: flush=%0b busy=%0b filter=%0d expected 0 0 %0d", flush, busy, filter_type, act_f);
      end
    end
    frame_txn(3, 0, 4'h0);
  endtask

  task automatic test_timeout();
    press_mask(4'b0001, 6);
    frame_txn(100, 1, 4'h0);
  endtask

  task automatic test_priority();
    while (tgt_f != 2) press_mask(4'b0001, 5);
    frame_txn(0, 0, 4'h0);
    press_mask(4'b1001, 6);
    frame_txn(0, 0, 4'h0);
    vectors++;
    if (filter_type !== 2'd0 || bypass !== 1'b0) begin
      miscompares++;
      $display("FAIL priority: filter=%0d bypass=%0b expected 0 0", filter_type, bypass);
    end
  endtask

  task automatic test_switch_press();
    press_mask(4'b0001, 6);
    frame_txn(0, 12, 4'b0100);
    frame_txn(0, 0, 4'h0);
    vectors++;
    if (bypass !== 1'b1) begin
      miscompares++;
      $display("FAIL deferred_bypass: got %0b expected 1", bypass);
    end
  endtask

  task automatic test_reset_mid();
    press_mask(4'b0001, 6);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    pipe_idle = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: busy=%0b timeout_err=%0b expected 1 1", busy, timeout_err);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({filter_type, bypass, flush, cfg_valid, busy, timeout_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL async_reset: got %b expected 0000000", {filter_type, bypass, flush, cfg_valid, busy, timeout_err});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pipe_idle = 1'b1;
    model_reset();
    frame_txn(0, 0, 4'h0);
  endtask

  task automatic test_random();
    logic [3:0] m;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) < 2) begin
        if ($urandom_range(0, 9) < 7) m = 4'b0001 << $urandom_range(0, 3);
        else m = 4'($urandom_range(1, 15));
        press_mask(m, $urandom_range(1, 8));
      end else begin
        frame_txn($urandom_range(0, 20), $urandom_range(0, 4), 4'h0);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_glitch();
    test_wrap();
    test_frame_sync();
    test_timeout();
    test_priority();
    test_switch_press();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
